// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and byte-counter width for fetch_sequencer
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALTED} fetch_state_e;
  localparam int FETCH_BEAT_W = 4;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches INST_W_BYTES bytes at pc from byte-wide imem, assembles and issues them
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pc / pc_en                  current program counter / one-cycle strobe per consumed instruction
//   imem_req/addr/gnt           byte read request channel (addr = pc + byte index)
//   imem_rvalid/rdata           byte read response channel
//   inst/inst_valid/inst_ready  assembled little-endian instruction to decoder
//   flush                       abandon current fetch and restart at pc byte 0
//   halt_req / halted           stop at next instruction boundary / core parked
//   stall_count                 cycles spent in FETCH or WAIT (only with FETCH_STALL_COUNT_EN, else 0)
// Build option: define FETCH_STALL_COUNT_EN to implement the saturating stall counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [I_ADDR_W-1:0]       pc,
  output logic                      pc_en,
  output logic                      imem_req,
  output logic [I_ADDR_W-1:0]       imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [7:0]                imem_rdata,
  output logic [8*INST_W_BYTES-1:0] inst,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  input  logic                      flush,
  input  logic                      halt_req,
  output logic                      halted,
  output logic [STALL_CNT_W-1:0]    stall_count
);
  fetch_state_e              state, state_nx;
  logic [FETCH_BEAT_W-1:0]   byte_idx, byte_idx_nx;
  logic [8*INST_W_BYTES-1:0] inst_nx;
  logic                      drop_pending, drop_nx;
  logic                      last;

  assign last = byte_idx == FETCH_BEAT_W'(INST_W_BYTES - 1);

  always_comb begin
    state_nx    = state;
    byte_idx_nx = byte_idx;
    inst_nx     = inst;
    drop_nx     = drop_pending;
    imem_req    = rst_n & (state == FETCH);
    imem_addr   = pc + I_ADDR_W'(byte_idx);
    inst_valid  = state == ISSUE;
    halted      = state == HALTED;
    pc_en       = inst_valid & inst_ready & ~flush;
    case (state)
      FETCH: begin
        if (flush) byte_idx_nx = '0;
        // a grant coinciding with flush still owes an rvalid, so it must be drained
        if (imem_gnt) begin
          state_nx = WAIT;
          drop_nx  = flush;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_nx = 1'b0;
          if (drop_pending | flush) begin
            byte_idx_nx = '0;
            state_nx    = FETCH;
          end else begin
            inst_nx[8*int'(byte_idx) +: 8] = imem_rdata;
            byte_idx_nx = last ? '0 : byte_idx + 1'b1;
            state_nx    = last ? ISSUE : FETCH;
          end
        end else if (flush) drop_nx = 1'b1;
      end
      ISSUE: begin
        if (flush) state_nx = FETCH;
        else if (inst_ready) state_nx = halt_req ? HALTED : FETCH;
      end
      HALTED: state_nx = halt_req ? HALTED : FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      byte_idx     <= '0;
      inst         <= '0;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_nx;
      byte_idx     <= byte_idx_nx;
      inst         <= inst_nx;
      drop_pending <= drop_nx;
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if ((state == FETCH || state == WAIT) && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer with a latency-configurable byte memory
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int NB = 2;
  localparam int SW = 16;
`ifdef FETCH_STALL_COUNT_EN
  localparam logic [SW-1:0] STALL1 = 4;
`else
  localparam logic [SW-1:0] STALL1 = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc;
  logic          pc_en;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [7:0]    imem_rdata;
  logic [8*NB-1:0] inst;
  logic          inst_valid;
  logic          inst_ready;
  logic          flush;
  logic          halt_req;
  logic          halted;
  logic [SW-1:0] stall_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.I_ADDR_W(AW), .INST_W_BYTES(NB), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .flush(flush), .halt_req(halt_req), .halted(halted), .stall_count(stall_count)
  );

  logic [7:0]    mem [0:4095];
  logic [AW-1:0] exp_addr [$];
  logic [8*NB-1:0] exp_inst [$];
  int n_tests = 0, n_fail = 0, pc_en_cnt = 0;
  int gnt_dly = 0, rv_dly = 1, stray_n = 0;
  int wait_cnt = 0, rv_cnt = 0;
  logic busy = 1'b0;
  logic [AW-1:0] pend = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic expect_inst(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a + 12'd1;
    exp_addr.push_back(a);
    exp_addr.push_back(b);
    exp_inst.push_back({mem[b], mem[a]});
  endtask

  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 100) begin step(); n++; end
    chk("halt_timeout", halted, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 100) begin step(); n++; end
    chk("valid_timeout", inst_valid, 1);
  endtask

  task automatic run_inst(input logic [AW-1:0] a);
    pc = a;
    expect_inst(a);
    halt_req = 1'b0;
    step();
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, a);
    halt_req = 1'b1;
    wait_halted();
  endtask

  // memory responder: grants after gnt_dly waiting cycles, returns data rv_dly cycles after grant
  initial begin
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (stray_n > 0) begin
        stray_n--;
        imem_rvalid = 1'b1;
        imem_rdata = 8'hEE;
        busy = 1'b0;
        wait_cnt = 0;
      end else if (!rst_n) begin
        busy = 1'b0;
        wait_cnt = 0;
      end else if (busy) begin
        rv_cnt++;
        if (rv_cnt >= rv_dly) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem[pend];
          busy = 1'b0;
        end
      end else if (imem_req) begin
        if (wait_cnt > 0) chk("addr_stable", imem_addr, pend);
        pend = imem_addr;
        if (wait_cnt >= gnt_dly) begin
          imem_gnt = 1'b1;
          busy = 1'b1;
          rv_cnt = 0;
          wait_cnt = 0;
          chk("addr_sb_nonempty", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) chk("addr", imem_addr, exp_addr.pop_front());
        end else wait_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_en) pc_en_cnt++;
      if (inst_valid && inst_ready && !flush) begin
        chk("pc_en_at_handshake", pc_en, 1);
        chk("inst_sb_nonempty", exp_inst.size() != 0, 1);
        if (exp_inst.size() != 0) chk("inst", inst, exp_inst.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
    mem[12'h010] = 8'h34; mem[12'h011] = 8'h12;
    mem[12'hFFF] = 8'hA5; mem[12'h000] = 8'h5C;
    mem[12'h600] = 8'h21; mem[12'h601] = 8'h43;
    inst_ready = 1'b1;
    flush = 1'b0;
    halt_req = 1'b1;
    pc = 12'h010;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_inst", inst, 0);
    chk("rst_stall", stall_count, 0);
    // zero-wait fetch straight out of reset; halt_req held so it parks after one instruction
    expect_inst(12'h010);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("t1_valid_early", inst_valid, 0);
    step();
    chk("t1_valid_c4", inst_valid, 1);
    chk("t1_inst", inst, 16'h1234);
    chk("t1_stall", stall_count, STALL1);
    step();
    chk("t6_halted", halted, 1);
    chk("t6_halt_req", imem_req, 0);
    chk("t1_pc_en_cnt", pc_en_cnt, 1);
    run_inst(12'h012);
    chk("t6_pc_en_cnt", pc_en_cnt, 2);
    repeat (3) step();
    chk("t6_hold_halted", halted, 1);
    chk("t6_hold_req", imem_req, 0);
    // slow memory
    gnt_dly = 3;
    rv_dly = 2;
    run_inst(12'h100);
    gnt_dly = 0;
    rv_dly = 1;
    chk("t2_pc_en_cnt", pc_en_cnt, 3);
    // decoder back-pressure
    pc = 12'h200;
    expect_inst(12'h200);
    inst_ready = 1'b0;
    halt_req = 1'b0;
    step();
    halt_req = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_hold", inst_valid, 1);
      chk("t3_inst_hold", inst, {mem[12'h201], mem[12'h200]});
      chk("t3_pc_en_low", pc_en, 0);
      step();
    end
    inst_ready = 1'b1;
    #1 chk("t3_pc_en_pulse", pc_en, 1);
    wait_halted();
    chk("t3_pc_en_cnt", pc_en_cnt, 4);
    // address wrap
    run_inst(12'hFFF);
    chk("t4_pc_en_cnt", pc_en_cnt, 5);
    // flush while waiting for byte 1; redirect to 0x400
    pc = 12'h300;
    rv_dly = 3;
    exp_addr.push_back(12'h300);
    exp_addr.push_back(12'h301);
    expect_inst(12'h400);
    halt_req = 1'b0;
    step();
    halt_req = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 12'h301) && n < 50) begin step(); n++; end
    chk("t5_reach_b1", imem_addr, 12'h301);
    step();
    flush = 1'b1;
    pc = 12'h400;
    #1 chk("t5_flush_valid", inst_valid, 0);
    chk("t5_flush_pc_en", pc_en, 0);
    step();
    flush = 1'b0;
    rv_dly = 1;
    wait_halted();
    chk("t5_pc_en_cnt", pc_en_cnt, 6);
    // flush during ISSUE with ready high suppresses pc_en and refetches
    pc = 12'h500;
    exp_addr.push_back(12'h500);
    exp_addr.push_back(12'h501);
    expect_inst(12'h500);
    inst_ready = 1'b0;
    halt_req = 1'b0;
    step();
    halt_req = 1'b1;
    wait_valid();
    inst_ready = 1'b1;
    flush = 1'b1;
    #1 chk("t5b_flush_pc_en", pc_en, 0);
    step();
    flush = 1'b0;
    chk("t5b_valid_drop", inst_valid, 0);
    wait_halted();
    chk("t5b_pc_en_cnt", pc_en_cnt, 7);
    // reset while waiting on read data, with stray rvalid during and just after reset
    pc = 12'h600;
    rv_dly = 4;
    expect_inst(12'h600);
    halt_req = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("t7_req", imem_req, 0);
    chk("t7_valid", inst_valid, 0);
    chk("t7_halted", halted, 0);
    chk("t7_pc_en", pc_en, 0);
    chk("t7_inst", inst, 0);
    chk("t7_stall", stall_count, 0);
    exp_addr.delete();
    exp_inst.delete();
    rv_dly = 1;
    gnt_dly = 1;
    expect_inst(12'h600);
    stray_n = 2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_halted();
    gnt_dly = 0;
    chk("t7_pc_en_cnt", pc_en_cnt, 8);
    chk("sb_addr_empty", exp_addr.size(), 0);
    chk("sb_inst_empty", exp_inst.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
